// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard and forwarding controller for the pipelined WISC core.
//               Tracks a shadow copy of the in-flight instructions from EX to
//               WB. From that copy it produces load-use stalls, per-operand EX
//               forwarding selects, a MEM store-data forward select and a
//               saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_W      = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic             id_src2_late,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_flush,
    input  logic             hold,
    output logic             stall,
    output logic [SEL_W-1:0] ex_fwd1_sel,
    output logic [SEL_W-1:0] ex_fwd2_sel,
    output logic [SEL_W-1:0] mem_fwd_sel,
    output logic [CNT_W-1:0] stall_count
);

    // One shadow-pipeline slot: everything needed to act as producer or consumer.
    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             load;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src1;
        logic             src1_used;
        logic [REG_W-1:0] src2;
        logic             src2_used;
        logic             src2_late;
    } entry_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    entry_t           r_pipe [DEPTH];
    entry_t           w_id_entry;
    logic             w_issue;
    logic             w_stall1;
    logic             w_stall2;
    logic             w_stall;
    logic [SEL_W-1:0] w_fwd1;
    logic [SEL_W-1:0] w_fwd2;
    logic [SEL_W-1:0] w_mfwd;
    logic [CNT_W-1:0] r_stall_count;

    // A producer satisfies a read of register s when it really writes s.
    // Register 0 is hardwired when ZERO_REG is set, so it never matches.
    function automatic logic f_match(input entry_t e, input logic [REG_W-1:0] s);
        return e.valid && e.wr && (e.dst == s) && !((ZERO_REG != 0) && (s == '0));
    endfunction

    // Pack the decode-stage fields into the entry that will enter EX.
    always_comb begin
        w_id_entry           = '0;
        w_id_entry.valid     = 1'b1;
        w_id_entry.wr        = id_wr;
        w_id_entry.load      = id_load;
        w_id_entry.dst       = id_dst;
        w_id_entry.src1      = id_src1;
        w_id_entry.src1_used = id_src1_used;
        w_id_entry.src2      = id_src2;
        w_id_entry.src2_used = id_src2_used;
        w_id_entry.src2_late = id_src2_late;
    end

    // Load-use detection. Walking from oldest to youngest lets the youngest
    // matching producer overwrite any older one, so only it decides.
    // A load at index k has its data k+1 cycles from now; a late operand
    // needs it one cycle later than an EX operand.
    always_comb begin
        int late2;
        w_stall1 = 1'b0;
        w_stall2 = 1'b0;
        late2    = id_src2_late ? 1 : 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (f_match(r_pipe[k], id_src1)) begin
                w_stall1 = r_pipe[k].load && (k + 1 < LOAD_READY);
            end
            if (f_match(r_pipe[k], id_src2)) begin
                w_stall2 = r_pipe[k].load && (k + 1 + late2 < LOAD_READY);
            end
        end
        w_stall = id_valid && !id_flush &&
                  ((id_src1_used && w_stall1) || (id_src2_used && w_stall2));
    end

    // Forwarding selects depend only on registered entries so they are
    // stable for the whole cycle the consumer spends in EX or MEM.
    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        w_mfwd = '0;
        if (r_pipe[0].valid && r_pipe[0].src1_used) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (f_match(r_pipe[k], r_pipe[0].src1)) begin
                    w_fwd1 = SEL_W'(k);
                end
            end
        end
        // Store data is picked up in MEM, so the EX operand mux stays on the
        // register-file path for a late src2.
        if (r_pipe[0].valid && r_pipe[0].src2_used && !r_pipe[0].src2_late) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                if (f_match(r_pipe[k], r_pipe[0].src2)) begin
                    w_fwd2 = SEL_W'(k);
                end
            end
        end
        if (r_pipe[1].valid && r_pipe[1].src2_used && r_pipe[1].src2_late) begin
            for (int k = DEPTH - 1; k >= 2; k--) begin
                if (f_match(r_pipe[k], r_pipe[1].src2)) begin
                    w_mfwd = SEL_W'(k);
                end
            end
        end
    end

    assign w_issue = id_valid && !id_flush && !w_stall;

    // Shadow pipeline: shifts one stage per unheld cycle; a stalled or killed
    // decode slot enters EX as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_pipe[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            r_pipe[0] <= w_issue ? w_id_entry : entry_t'('0);
        end
    end

    // Performance counter: counts cycles that actually cost a bubble and
    // sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && !hold && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall       = w_stall;
    assign ex_fwd1_sel = w_fwd1;
    assign ex_fwd2_sel = w_fwd2;
    assign mem_fwd_sel = w_mfwd;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
